// File: rtl/xor_scrambler.sv
// Additive (XOR) scrambler/descrambler with an LFSR keystream.
// The same block scrambles on TX and descrambles on RX, because XOR with an identical keystream undoes itself.
// It has a single registered output stage with valid/ready handshakes on both sides.
// Each frame can be reseeded, and a bypass mode passes data through unchanged.
module xor_scrambler #(
  parameter int                  WIDTH    = 8,
  parameter int                  LFSR_LEN = 7,
  parameter logic [LFSR_LEN-1:0] POLY     = 7'h60,
  parameter logic [LFSR_LEN-1:0] SEED     = 7'h7F
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                mode_in,
  input  logic                seed_load_in,
  input  logic [LFSR_LEN-1:0] seed_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_sof,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_sof,
  output logic [LFSR_LEN-1:0] lfsr_state_out
);

  logic [LFSR_LEN-1:0] lfsr;
  logic [LFSR_LEN-1:0] seed_q;
  logic [LFSR_LEN-1:0] seed_sanitised;
  logic [LFSR_LEN-1:0] seed_eff;
  logic [LFSR_LEN-1:0] start_state;
  logic [LFSR_LEN-1:0] step_state;
  logic [LFSR_LEN-1:0] adv_state;
  logic [WIDTH-1:0]    key;
  logic                accept;

  // The output register can take a new beat when it is empty or is being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A zero seed would lock the LFSR, so it is replaced with the default seed.
  assign seed_sanitised = (seed_in == '0) ? SEED : seed_in;

  // A seed written in the same cycle as a start-of-frame beat already applies to that beat.
  assign seed_eff = seed_load_in ? seed_sanitised : seed_q;

  assign lfsr_state_out = lfsr;

  // Pick the LFSR state this beat starts from: the seed on a new frame, otherwise the running state.
  always_comb begin
    start_state = lfsr;
    if (in_sof) begin
      start_state = seed_eff;
    end
    if (start_state == '0) begin
      start_state = SEED;
    end
  end

  // Step the LFSR WIDTH times, LSB first, collecting each MSB as a key bit.
  always_comb begin
    step_state = start_state;
    key        = '0;
    for (int j = 0; j < WIDTH; j++) begin
      key[j]     = step_state[LFSR_LEN-1];
      step_state = {step_state[LFSR_LEN-2:0], ^(step_state & POLY)};
    end
    adv_state = step_state;
  end

  // The seed register updates whenever it is written, regardless of the data handshake.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      seed_q <= SEED;
    end else if (seed_load_in) begin
      seed_q <= seed_sanitised;
    end
  end

  // This is the output stage and keystream state.
  // Both change only on an accepted beat; out_valid clears once the held beat is taken.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      lfsr      <= SEED;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sof   <= in_sof;
      if (mode_in) begin
        out_data <= in_data ^ key;
        lfsr     <= adv_state;
      end else begin
        out_data <= in_data;
        lfsr     <= start_state;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xor_scrambler.sv
// Directed testbench for xor_scrambler.
// Expected keystream values are hand-derived from x^7+x^6+1 with seed 7'h7F.
// A scrambler/descrambler pair is chained to check that a random stream comes back bit-exact.
module tb_xor_scrambler;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic       seed_load;
  logic [6:0] seed;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sof;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sof;
  logic [6:0] lfsr_state;

  logic       rt_valid;
  logic       rt_ready;
  logic [7:0] rt_data;
  logic       rt_sof;
  logic       mid_valid;
  logic       mid_ready;
  logic [7:0] mid_data;
  logic       mid_sof;
  logic [6:0] scr_lfsr;
  logic       dscr_valid;
  logic [7:0] dscr_data;
  logic       dscr_sof;
  logic [6:0] dscr_lfsr;

  int         checks;
  int         errors;
  int         rx_count;
  logic [7:0] rt_vec [64];

  xor_scrambler dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .mode_in        (mode),
    .seed_load_in   (seed_load),
    .seed_in        (seed),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_sof         (in_sof),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_sof        (out_sof),
    .lfsr_state_out (lfsr_state)
  );

  xor_scrambler scr (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .mode_in        (1'b1),
    .seed_load_in   (1'b0),
    .seed_in        (7'h00),
    .in_valid       (rt_valid),
    .in_ready       (rt_ready),
    .in_data        (rt_data),
    .in_sof         (rt_sof),
    .out_valid      (mid_valid),
    .out_ready      (mid_ready),
    .out_data       (mid_data),
    .out_sof        (mid_sof),
    .lfsr_state_out (scr_lfsr)
  );

  xor_scrambler dscr (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .mode_in        (1'b1),
    .seed_load_in   (1'b0),
    .seed_in        (7'h00),
    .in_valid       (mid_valid),
    .in_ready       (mid_ready),
    .in_data        (mid_data),
    .in_sof         (mid_sof),
    .out_valid      (dscr_valid),
    .out_ready      (1'b1),
    .out_data       (dscr_data),
    .out_sof        (dscr_sof),
    .lfsr_state_out (dscr_lfsr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic exp_valid, input logic [7:0] exp_data,
                             input logic exp_sof, input logic [6:0] exp_lfsr);
    checkVal({tag, ".valid"}, 32'(out_valid), 32'(exp_valid));
    checkVal({tag, ".data"}, 32'(out_data), 32'(exp_data));
    checkVal({tag, ".sof"}, 32'(out_sof), 32'(exp_sof));
    checkVal({tag, ".lfsr"}, 32'(lfsr_state), 32'(exp_lfsr));
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic sof, input logic m,
                               input logic load, input logic [6:0] s);
    in_valid  = v;
    in_data   = d;
    in_sof    = sof;
    mode      = m;
    seed_load = load;
    seed      = s;
    @(posedge clk);
    #1;
  endtask

  task automatic collectRoundTrip();
    if (dscr_valid) begin
      if (rx_count < 64) begin
        checkVal($sformatf("roundtrip[%0d]", rx_count), 32'(dscr_data), 32'(rt_vec[rx_count]));
      end
      rx_count++;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rx_count  = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_sof    = 1'b0;
    mode      = 1'b1;
    seed_load = 1'b0;
    seed      = 7'h00;
    rt_valid  = 1'b0;
    rt_data   = 8'h00;
    rt_sof    = 1'b0;
    for (int i = 0; i < 64; i++) rt_vec[i] = 8'($urandom_range(0, 255));

    @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 8'h00, 1'b0, 7'h7F);
    checkVal("reset.in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    applyStimulus(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 7'h00);
    checkOutput("beat1_sof", 1'b1, 8'h7F, 1'b1, 7'h02);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 7'h00);
    checkOutput("beat2", 1'b1, 8'h20, 1'b0, 7'h0C);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'h00);
    checkVal("idle.valid", 32'(out_valid), 32'd0);
    checkVal("idle.lfsr", 32'(lfsr_state), 32'h0C);

    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 7'h00);
    checkOutput("bypass", 1'b1, 8'hA5, 1'b0, 7'h0C);

    applyStimulus(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 7'h01);
    checkOutput("seed01_same_cycle", 1'b1, 8'h40, 1'b1, 7'h06);
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 7'h00);
    checkOutput("seed01_retained", 1'b1, 8'h40, 1'b1, 7'h06);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 7'h00);
    checkVal("seed0_load.lfsr", 32'(lfsr_state), 32'h06);
    checkVal("seed0_load.valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 7'h00);
    checkOutput("seed0_fallback", 1'b1, 8'h7F, 1'b1, 7'h02);

    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 7'h00);
      checkVal($sformatf("stall%0d.in_ready", i), 32'(in_ready), 32'd0);
      checkOutput($sformatf("stall%0d", i), 1'b1, 8'h7F, 1'b1, 7'h02);
    end
    out_ready = 1'b1;
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 7'h00);
    checkOutput("release", 1'b1, 8'h31, 1'b0, 7'h0C);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 7'h00);
    checkOutput("back_to_back", 1'b1, 8'h18, 1'b0, 7'h28);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'h00);
    checkVal("drain.valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 64; i++) begin
      rt_valid = 1'b1;
      rt_data  = rt_vec[i];
      rt_sof   = (i == 0);
      @(posedge clk);
      #1;
      collectRoundTrip();
    end
    rt_valid = 1'b0;
    rt_sof   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      collectRoundTrip();
    end
    checkVal("roundtrip.count", 32'(rx_count), 32'd64);

    out_ready = 1'b0;
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 7'h00);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'h00);
    checkVal("midframe.valid_before_reset", 32'(out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, 8'h00, 1'b0, 7'h7F);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 7'h00);
    checkOutput("restart_after_reset", 1'b1, 8'h7F, 1'b1, 7'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
